// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match, sticky PEND flag and optional level irq.
// Define MMIO_TIMER_IRQ_EN to implement the CTRL.IE bit and the irq output; otherwise irq is tied low.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_en,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        irq
);

  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_COUNT   = 2'd1;
  localparam logic [1:0] OFF_COMPARE = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;

  logic        ctrl_en;
  logic        ctrl_periodic;
  logic        ctrl_ie;
  logic [7:0]  ctrl_prescale;
  logic [7:0]  pcnt;
  logic [31:0] count;
  logic [31:0] compare;
  logic        pend;

  logic [7:0]  pcnt_next;
  logic [31:0] count_next;
  logic        pend_next;
  logic        tick;
  logic        match;
  logic        wr_ctrl;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;

  assign hit        = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_ctrl    = write_en && hit && (addr[3:2] == OFF_CTRL);
  assign wr_count   = write_en && hit && (addr[3:2] == OFF_COUNT);
  assign wr_compare = write_en && hit && (addr[3:2] == OFF_COMPARE);
  assign wr_status  = write_en && hit && (addr[3:2] == OFF_STATUS);

  // Matches are judged on pre-edge COUNT/COMPARE, so same-edge software writes never hide a match.
  assign tick  = ctrl_en && (pcnt == ctrl_prescale);
  assign match = tick && (count == compare);

  always_comb begin
    pcnt_next  = pcnt + 8'd1;
    count_next = count;
    pend_next  = pend;

    if (wr_ctrl || !ctrl_en || tick)
      pcnt_next = '0;

    if (wr_count)
      count_next = write_data;
    else if (tick)
      count_next = (match && ctrl_periodic) ? '0 : count + 32'd1;

    // A new match outranks a simultaneous write-1-to-clear.
    if (match)
      pend_next = 1'b1;
    else if (wr_status && write_data[0])
      pend_next = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en       <= 1'b0;
      ctrl_periodic <= 1'b0;
      ctrl_prescale <= '0;
      pcnt          <= '0;
      count         <= '0;
      compare       <= '1;
      pend          <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en       <= write_data[0];
        ctrl_periodic <= write_data[1];
        ctrl_prescale <= write_data[15:8];
      end
      if (wr_compare)
        compare <= write_data;
      pcnt  <= pcnt_next;
      count <= count_next;
      pend  <= pend_next;
    end
  end

`ifdef MMIO_TIMER_IRQ_EN
  logic ie_next;
  logic irq_q;

  assign ie_next = wr_ctrl ? write_data[2] : ctrl_ie;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_ie <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ctrl_ie <= ie_next;
      irq_q   <= pend_next && ie_next;
    end
  end

  assign irq = irq_q;
`else
  assign ctrl_ie = 1'b0;
  assign irq     = 1'b0;
`endif

  always_comb begin
    read_data = '0;
    if (hit) begin
      case (addr[3:2])
        OFF_CTRL:    read_data = {16'd0, ctrl_prescale, 5'd0, ctrl_ie, ctrl_periodic, ctrl_en};
        OFF_COUNT:   read_data = count;
        OFF_COMPARE: read_data = compare;
        OFF_STATUS:  read_data = {31'd0, pend};
        default:     read_data = '0;
      endcase
    end
  end

endmodule
